// File: rtl/program_counter_unit.sv
// Registered program counter with split page/high fields, per-field loads, inc/dec
// and a relative branch that spends one extra cycle fixing the high field on a page cross.
module program_counter_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                PAGE_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     load_lo,
  input  logic                     load_hi,
  input  logic [PAGE_W-1:0]        load_data,
  input  logic                     inc,
  input  logic                     dec,
  input  logic                     branch,
  input  logic [PAGE_W-1:0]        offset,
  output logic [ADDR_W-1:0]        pc,
  output logic [PAGE_W-1:0]        pc_lo,
  output logic [ADDR_W-PAGE_W-1:0] pc_hi,
  output logic                     busy
);

  localparam int HI_W = ADDR_W - PAGE_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FIXUP = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [PAGE_W-1:0] lo_r, lo_s;
  logic [HI_W-1:0]   hi_r, hi_s;
  logic              dir_r, dir_s;   // 1 = fix up downwards
  logic [PAGE_W:0]   br_sum_s;
  logic              br_cross_s;
  logic [ADDR_W-1:0] pc_inc_s, pc_dec_s;
  logic [HI_W-1:0]   hi_load_s, hi_one_s;

  // Arithmetic shared by branch, inc/dec and the fixup cycle.
  always_comb begin
    br_sum_s   = {1'b0, lo_r} + {1'b0, offset};
    // A negative offset borrows exactly when the unsigned add does not carry.
    br_cross_s = offset[PAGE_W-1] ? ~br_sum_s[PAGE_W] : br_sum_s[PAGE_W];
    pc_inc_s   = {hi_r, lo_r} + {{(ADDR_W-1){1'b0}}, 1'b1};
    pc_dec_s   = {hi_r, lo_r} - {{(ADDR_W-1){1'b0}}, 1'b1};
    hi_load_s  = HI_W'(load_data);
    hi_one_s   = {{(HI_W-1){1'b0}}, 1'b1};
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_s = state_r;
    lo_s    = lo_r;
    hi_s    = hi_r;
    dir_s   = dir_r;
    case (state_r)
      IDLE: begin
        if (load_lo || load_hi) begin
          if (load_lo) begin
            lo_s = load_data;
          end else begin
            lo_s = lo_r;
          end
          if (load_hi) begin
            hi_s = hi_load_s;
          end else begin
            hi_s = hi_r;
          end
        end else if (branch) begin
          lo_s = br_sum_s[PAGE_W-1:0];
          if (br_cross_s) begin
            state_s = FIXUP;
            dir_s   = offset[PAGE_W-1];
          end else begin
            state_s = IDLE;
          end
        end else if (inc) begin
          {hi_s, lo_s} = pc_inc_s;
        end else if (dec) begin
          {hi_s, lo_s} = pc_dec_s;
        end else begin
          state_s = IDLE;
        end
      end
      FIXUP: begin
        if (dir_r) begin
          hi_s = hi_r - hi_one_s;
        end else begin
          hi_s = hi_r + hi_one_s;
        end
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r      <= IDLE;
      {hi_r, lo_r} <= RESET_PC;
      dir_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      lo_r    <= lo_s;
      hi_r    <= hi_s;
      dir_r   <= dir_s;
    end
  end

  assign pc_lo = lo_r;
  assign pc_hi = hi_r;
  assign pc    = {hi_r, lo_r};
  assign busy  = (state_r == FIXUP);

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit: one task per feature, inline comparisons.
module tb_program_counter_unit;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        load_lo = 1'b0, load_hi = 1'b0, inc = 1'b0, dec = 1'b0, branch = 1'b0;
  logic [7:0]  load_data = 8'h00, offset = 8'h00;
  logic [15:0] pc;
  logic [7:0]  pc_lo, pc_hi;
  logic        busy;
  int          errors = 0;
  int          checks = 0;

  program_counter_unit #(.ADDR_W(16), .PAGE_W(8), .RESET_PC(16'h0000)) dut (
    .clk(clk), .nrst(nrst), .load_lo(load_lo), .load_hi(load_hi), .load_data(load_data),
    .inc(inc), .dec(dec), .branch(branch), .offset(offset),
    .pc(pc), .pc_lo(pc_lo), .pc_hi(pc_hi), .busy(busy)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, pass one rising edge, then release all commands.
  task automatic cyc(input logic llo, input logic lhi, input logic [7:0] d,
                     input logic i, input logic de, input logic br, input logic [7:0] off);
    load_lo = llo; load_hi = lhi; load_data = d; inc = i; dec = de; branch = br; offset = off;
    @(posedge clk); #1;
    load_lo = 1'b0; load_hi = 1'b0; inc = 1'b0; dec = 1'b0; branch = 1'b0;
  endtask

  task automatic set_pc(input logic [15:0] v);
    cyc(1'b1, 1'b0, v[7:0], 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, v[15:8], 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 16'h0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want %b", busy, 1'b0); end
    set_pc(16'h12F8);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b want %b", busy, 1'b1); end
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_in_fixup_pc: got %h want %h", pc, 16'h0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_in_fixup_busy: got %b want %b", busy, 1'b0); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_abandon: got %h want %h", pc, 16'h0000); end
  endtask

  task automatic test_load;
    cyc(1'b1, 1'b0, 8'h34, 1'b1, 1'b0, 1'b1, 8'h40);
    checks++; if (pc !== 16'h0034) begin errors++; $display("FAIL load_lo_only: got %h want %h", pc, 16'h0034); end
    cyc(1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL load_hi_only: got %h want %h", pc, 16'h1234); end
    checks++; if (pc_lo !== 8'h34 || pc_hi !== 8'h12) begin errors++;
      $display("FAIL load_fields: got %h/%h want %h/%h", pc_hi, pc_lo, 8'h12, 8'h34); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'h1235) begin errors++; $display("FAIL load_then_inc: got %h want %h", pc, 16'h1235); end
    cyc(1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'hABAB) begin errors++; $display("FAIL load_both: got %h want %h", pc, 16'hABAB); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'hABAB) begin errors++; $display("FAIL hold: got %h want %h", pc, 16'hABAB); end
  endtask

  task automatic test_inc_dec;
    set_pc(16'hFFFF);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h want %h", pc, 16'h0000); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL dec_wrap: got %h want %h", pc, 16'hFFFF); end
    set_pc(16'h1000);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (pc !== 16'h0FFF) begin errors++; $display("FAIL dec_borrow: got %h want %h", pc, 16'h0FFF); end
    set_pc(16'h1000);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    checks++; if (pc !== 16'h1001) begin errors++; $display("FAIL inc_dec_both: got %h want %h", pc, 16'h1001); end
    set_pc(16'h12FF);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'h1300 || busy !== 1'b0) begin errors++;
      $display("FAIL inc_carry: got %h busy %b want %h busy 0", pc, busy, 16'h1300); end
  endtask

  task automatic test_branch_fwd;
    set_pc(16'h12F8);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10);
    checks++; if (pc !== 16'h1208 || busy !== 1'b1) begin errors++;
      $display("FAIL br_fwd_mid: got %h busy %b want %h busy 1", pc, busy, 16'h1208); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'h1308 || busy !== 1'b0) begin errors++;
      $display("FAIL br_fwd_end: got %h busy %b want %h busy 0", pc, busy, 16'h1308); end
  endtask

  task automatic test_branch_back;
    set_pc(16'h1205);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hF0);
    checks++; if (pc !== 16'h12F5 || busy !== 1'b1) begin errors++;
      $display("FAIL br_back_mid: got %h busy %b want %h busy 1", pc, busy, 16'h12F5); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'h11F5 || busy !== 1'b0) begin errors++;
      $display("FAIL br_back_end: got %h busy %b want %h busy 0", pc, busy, 16'h11F5); end
    set_pc(16'h1200);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05);
    checks++; if (pc !== 16'h1205 || busy !== 1'b0) begin errors++;
      $display("FAIL br_same_page: got %h busy %b want %h busy 0", pc, busy, 16'h1205); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'h1205 || busy !== 1'b0) begin errors++;
      $display("FAIL br_same_page_after: got %h busy %b want %h busy 0", pc, busy, 16'h1205); end
    set_pc(16'h1220);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hF0);
    checks++; if (pc !== 16'h1210 || busy !== 1'b0) begin errors++;
      $display("FAIL br_back_no_borrow: got %h busy %b want %h busy 0", pc, busy, 16'h1210); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (pc !== 16'h1210 || busy !== 1'b0) begin errors++;
      $display("FAIL br_zero: got %h busy %b want %h busy 0", pc, busy, 16'h1210); end
    cyc(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'hF0);
    checks++; if (pc !== 16'h1277 || busy !== 1'b0) begin errors++;
      $display("FAIL load_over_branch: got %h busy %b want %h busy 0", pc, busy, 16'h1277); end
  endtask

  task automatic test_fixup_ignore_and_wrap;
    set_pc(16'h12F8);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10);
    cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h40);
    checks++; if (pc !== 16'h1308 || busy !== 1'b0) begin errors++;
      $display("FAIL fixup_ignore: got %h busy %b want %h busy 0", pc, busy, 16'h1308); end
    set_pc(16'hFFF0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h20);
    checks++; if (pc !== 16'hFF10 || busy !== 1'b1) begin errors++;
      $display("FAIL wrap_up_mid: got %h busy %b want %h busy 1", pc, busy, 16'hFF10); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL wrap_up_end: got %h want %h", pc, 16'h0010); end
    set_pc(16'h0005);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hF0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 16'hFFF5) begin errors++; $display("FAIL wrap_down_end: got %h want %h", pc, 16'hFFF5); end
  endtask

  task automatic test_back_to_back;
    set_pc(16'h01FE);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h04);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFC);
    checks++; if (pc !== 16'h02FE || busy !== 1'b1) begin errors++;
      $display("FAIL b2b_mid: got %h busy %b want %h busy 1", pc, busy, 16'h02FE); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (pc !== 16'h01FD) begin errors++; $display("FAIL b2b_end: got %h want %h", pc, 16'h01FD); end
  endtask

  initial begin
    nrst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_load();
    test_inc_dec();
    test_branch_fwd();
    test_branch_back();
    test_fixup_ignore_and_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
